// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment constants and BCD encoder
package seg_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low pattern, dp off; anything outside 0..9 renders blank.
    function automatic logic [7:0] seg_encode(input logic [DIGIT_W-1:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_updown_digit.sv
// rtl/bcd_updown_digit.sv - one up/down decade with clear and saturating load
module bcd_updown_digit
    import seg_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               up_dn,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_d,
    output logic [DIGIT_W-1:0] q,
    output logic               at_max,
    output logic               at_min
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= (load_d > 4'd9) ? 4'd9 : load_d;
        end else if (en) begin
            if (up_dn) begin
                q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
            end else begin
                q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
            end
        end
    end

    assign at_max = (q == 4'd9);
    assign at_min = (q == 4'd0);

endmodule

// File: rtl/seg_bcd_counter_disp.sv
// rtl/seg_bcd_counter_disp.sv - N-digit BCD up/down counter with multiplexed 7-seg driver
module seg_bcd_counter_disp
    import seg_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic                      up_dn,
    input  logic                      clr,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    input  logic                      blank_lz,
    output logic [DIGIT_W*DIGITS-1:0] count_bcd,
    output logic                      tick,
    output logic                      wrap,
    output logic [DIGITS-1:0]         seg_sel,
    output logic [7:0]                seg_data
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]      presc;
    logic               step;
    logic               step_eff;
    logic [DIGITS:0]    chain;
    logic [DIGITS-1:0]  at_max;
    logic [DIGITS-1:0]  at_min;
    logic [DIGIT_W-1:0] digit_q [DIGITS];
    logic [DIGITS-1:0]  nz_hi;
    logic               blank_cur;
    logic [SW-1:0]      scan_cnt;
    logic [IW-1:0]      scan_idx;

    assign step     = run && (presc == PW'(TICK_DIV - 1));
    assign step_eff = step && !clr && !load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (clr || load || step) begin
            presc <= '0;
        end else if (run) begin
            presc <= presc + 1'b1;
        end
    end

    // chain[k] is high when every digit below k sits at its rollover value
    // for the current direction, so digit k moves on this step.
    assign chain[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign chain[k+1] = chain[k] & (up_dn ? at_max[k] : at_min[k]);

        bcd_updown_digit u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (step & chain[k]),
            .up_dn  (up_dn),
            .clr    (clr),
            .load   (load),
            .load_d (load_val[k*DIGIT_W +: DIGIT_W]),
            .q      (digit_q[k]),
            .at_max (at_max[k]),
            .at_min (at_min[k])
        );

        assign count_bcd[k*DIGIT_W +: DIGIT_W] = digit_q[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            tick <= step_eff;
            wrap <= step_eff & chain[DIGITS];
        end
    end

    // nz_hi[k]: some digit at position k or above is non-zero.
    always_comb begin
        logic acc;
        acc   = 1'b0;
        nz_hi = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc      = acc | (digit_q[k] != 4'd0);
            nz_hi[k] = acc;
        end
    end

    assign blank_cur = blank_lz && (scan_idx != '0) && !nz_hi[scan_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            seg_sel  <= '1;
            seg_data <= SEG_BLANK;
        end else begin
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            seg_sel  <= ~(DIGITS'(1) << scan_idx);
            seg_data <= blank_cur ? SEG_BLANK : seg_encode(digit_q[scan_idx]);
        end
    end

endmodule

// File: tb/tb_seg_bcd_counter_disp.sv
// tb/tb_seg_bcd_counter_disp.sv - directed scoreboard bench for seg_bcd_counter_disp
module tb_seg_bcd_counter_disp;

    localparam int DIGITS   = 3;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        up_dn;
    logic        clr;
    logic        load;
    logic [11:0] load_val;
    logic        blank_lz;
    logic [11:0] count_bcd;
    logic        tick;
    logic        wrap;
    logic [2:0]  seg_sel;
    logic [7:0]  seg_data;

    int errors = 0;
    int checks = 0;

    logic [12:0] tick_q[$];
    logic [10:0] scan_q[$];

    always #5 clk = ~clk;

    seg_bcd_counter_disp #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .up_dn     (up_dn),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .blank_lz  (blank_lz),
        .count_bcd (count_bcd),
        .tick      (tick),
        .wrap      (wrap),
        .seg_sel   (seg_sel),
        .seg_data  (seg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int maxc, output int cyc);
        bit          seen;
        logic [12:0] e;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            step_clk();
            cyc++;
            if (tick === 1'b1) seen = 1'b1;
        end
        chk("tick_seen", {31'd0, seen}, 32'd1);
        if (tick_q.size() > 0) begin
            e = tick_q.pop_front();
            chk("tick_count", {20'd0, count_bcd}, {20'd0, e[11:0]});
            chk("tick_wrap", {31'd0, wrap}, {31'd0, e[12]});
        end
    endtask

    task automatic scan_run();
        logic [2:0]  prev;
        bit          found;
        logic [10:0] e;
        prev  = seg_sel;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step_clk();
            if (seg_sel == 3'b110 && prev != 3'b110) found = 1'b1;
            prev = seg_sel;
        end
        chk("scan_sync", {31'd0, found}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step_clk();
            e = scan_q.pop_front();
            chk("scan_sel", {29'd0, seg_sel}, {29'd0, e[10:8]});
            chk("scan_data", {24'd0, seg_data}, {24'd0, e[7:0]});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n    = 1'b0;
        run      = 1'b0;
        up_dn    = 1'b1;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        blank_lz = 1'b0;
        repeat (3) step_clk();
        chk("rst_count", {20'd0, count_bcd}, 32'h0);
        chk("rst_sel", {29'd0, seg_sel}, 32'h7);
        chk("rst_data", {24'd0, seg_data}, 32'hFF);
        chk("rst_tick", {31'd0, tick}, 32'h0);
        chk("rst_wrap", {31'd0, wrap}, 32'h0);

        // count up 001..009, 010 with a step every TICK_DIV cycles
        rst_n = 1'b1;
        run   = 1'b1;
        for (int i = 1; i <= 9; i++) tick_q.push_back({1'b0, 12'(i)});
        tick_q.push_back({1'b0, 12'h010});
        for (int i = 0; i < 10; i++) begin
            wait_tick(10, cyc);
            chk("tick_period", cyc, 4);
        end

        // asynchronous reset mid-count clears everything at once
        #3 rst_n = 1'b0;
        #1;
        chk("arst_count", {20'd0, count_bcd}, 32'h0);
        chk("arst_sel", {29'd0, seg_sel}, 32'h7);
        chk("arst_data", {24'd0, seg_data}, 32'hFF);
        chk("arst_tick", {31'd0, tick}, 32'h0);
        run = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // load 998, count up through 999 to 000 with wrap
        load_val = 12'h998;
        load     = 1'b1;
        step_clk();
        load = 1'b0;
        chk("load_998", {20'd0, count_bcd}, 32'h998);
        run   = 1'b1;
        up_dn = 1'b1;
        tick_q.push_back({1'b0, 12'h999});
        tick_q.push_back({1'b1, 12'h000});
        for (int i = 0; i < 2; i++) begin
            wait_tick(10, cyc);
            chk("load_period", cyc, 4);
        end
        step_clk();
        chk("wrap_pulse", {31'd0, wrap}, 32'h0);
        chk("tick_pulse", {31'd0, tick}, 32'h0);

        // clear then count down through 000 -> 999 -> 998
        clr   = 1'b1;
        up_dn = 1'b0;
        step_clk();
        clr = 1'b0;
        chk("clr_count", {20'd0, count_bcd}, 32'h0);
        tick_q.push_back({1'b1, 12'h999});
        tick_q.push_back({1'b0, 12'h998});
        for (int i = 0; i < 2; i++) wait_tick(10, cyc);

        // saturating load, then clr beats load
        load_val = 12'h1AF;
        load     = 1'b1;
        step_clk();
        load = 1'b0;
        chk("load_sat", {20'd0, count_bcd}, 32'h199);
        load_val = 12'h123;
        clr      = 1'b1;
        load     = 1'b1;
        step_clk();
        clr  = 1'b0;
        load = 1'b0;
        chk("clr_over_load", {20'd0, count_bcd}, 32'h0);
        chk("clr_no_tick", {31'd0, tick}, 32'h0);

        // pause with the prescaler at 2
        up_dn = 1'b1;
        step_clk();
        step_clk();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_clk();
            chk("pause_tick", {31'd0, tick}, 32'h0);
        end
        chk("pause_count", {20'd0, count_bcd}, 32'h0);
        run = 1'b1;
        tick_q.push_back({1'b0, 12'h001});
        step_clk();
        chk("resume_tick0", {31'd0, tick}, 32'h0);
        step_clk();
        chk("resume_tick1", {31'd0, tick}, 32'h1);
        begin
            logic [12:0] e;
            e = tick_q.pop_front();
            chk("resume_count", {20'd0, count_bcd}, {20'd0, e[11:0]});
        end

        // scan with and without leading-zero blanking
        run      = 1'b0;
        load_val = 12'h005;
        load     = 1'b1;
        blank_lz = 1'b1;
        step_clk();
        load = 1'b0;
        step_clk();
        repeat (2) scan_q.push_back({3'b110, 8'h92});
        repeat (2) scan_q.push_back({3'b101, 8'hFF});
        repeat (2) scan_q.push_back({3'b011, 8'hFF});
        scan_run();
        blank_lz = 1'b0;
        step_clk();
        repeat (2) scan_q.push_back({3'b110, 8'h92});
        repeat (2) scan_q.push_back({3'b101, 8'hC0});
        repeat (2) scan_q.push_back({3'b011, 8'hC0});
        scan_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_bcd_counter_disp.md
Name: seg_bcd_counter_disp

Overview:
Parametrised N-digit BCD event/time counter with an integrated multiplexed seven-segment driver.
- Generalises the fixed 6-digit up-counter display: configurable digit count and tick period, up/down counting, run/pause, synchronous clear and load, wrap flag, and optional leading-zero blanking.
- Sits between the board clock/reset and the common-anode seven-segment header; drives digit select and segment lines directly.

Parameters:
DIGITS, 6, number of BCD digits and scan positions (legal range 1..8)
TICK_DIV, 50_000_000, clk cycles per count step (≥2)
SCAN_DIV, 50_000, clk cycles each digit stays selected (≥2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
run  in  1  1 = prescaler advances; 0 = pause (prescaler and count hold)
up_dn  in  1  1 = count up, 0 = count down; sampled at each step
clr  in  1  synchronous clear of count and prescaler
load  in  1  synchronous load of load_val
load_val  in  4*DIGITS  BCD load value, digit 0 in bits [3:0]
blank_lz  in  1  1 = blank leading zeros
count_bcd  out  4*DIGITS  current count, digit 0 = LSD
tick  out  1  one-cycle pulse on every count step
wrap  out  1  one-cycle pulse when a step wraps (all-9 to all-0 up, all-0 to all-9 down)
seg_sel  out  DIGITS  digit select, active-low, one-hot-low
seg_data  out  8  segments active-low, bit7 = dp (always 1/off), bits6..0 = g..a

Behaviour:
- Reset values: count_bcd 0, prescaler 0, tick 0, wrap 0, scan counter 0, scan index 0, seg_sel all ones, seg_data 8'hFF. Asserting rst_n low mid-operation forces these values immediately, with no residual pulse.
- Prescaler runs 0..TICK_DIV-1 while run=1. step = run && (presc == TICK_DIV-1). On step, prescaler returns to 0. While run=0, the prescaler holds its value.
- Priority per cycle is clr > load > step:
  - clr: count and prescaler go to 0; tick and wrap stay 0.
  - load: count takes load_val, with any digit >9 saturated to 9; prescaler goes to 0; no tick.
  - step: count updates on the same edge that tick goes high. Latency from the terminal prescaler value is one edge.
- Up step: digit 0 +1. Digit k increments when all lower digits are 9. Each digit wraps 9 to 0. All-9 goes to all-0 with wrap=1 for that cycle.
- Down step: digit 0 -1. Digit k decrements when all lower digits are 0. Each digit wraps 0 to 9. All-0 goes to all-9 with wrap=1.
- tick and wrap are registered single-cycle pulses. They never assert on clr, load or reset.
- Scan: scan counter runs 0..SCAN_DIV-1 continuously, independent of run, clr and load. On wrap, index advances i to i+1 and DIGITS-1 to 0.
  - seg_sel and seg_data are registered from the current index and count, giving 1-cycle latency.
  - seg_sel[idx]=0 and all other bits are 1.
- Decode, active-low with dp off: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
- Blanking: with blank_lz=1, digit k>0 shows FF when it and all higher digits are 0. Digit 0 is never blanked.
- count_bcd is always valid BCD. Arithmetic is per-digit 4-bit with no binary carry between digits.

Decomposition:
- Shared package seg_pkg: SEG_0..SEG_9 constants, SEG_BLANK=8'hFF, seg_encode function (4-bit BCD to 8-bit active-low pattern, FF for >9), digit width constant 4.
- One sub-module bcd_updown_digit: one decade with en, up_dn, clr, load, load_d; outputs q, at_max (q==9), at_min (q==0).
- Top level generates DIGITS instances plus the prescaler, carry/borrow chain, blanking and scan.

Test Plan:
1. Params DIGITS=3, TICK_DIV=4, SCAN_DIV=2. Release rst_n, run=1, up_dn=1 -> tick every 4 cycles, count 000,001,...,009,010. Drop rst_n mid-count -> count 000, seg_sel 111, seg_data FF the same cycle.
2. load 0x998, then run up -> 999, then 000 with wrap=1 for exactly one cycle, coincident with tick.
3. clr, up_dn=0, run -> 000 to 999 with wrap=1. Next step -> 998, wrap=0.
4. load_val 0x1AF -> count 0x199. clr and load in the same cycle -> count 000, no tick.
5. run=0 at presc=2 for 10 cycles -> count and presc hold, no tick. run=1 -> next tick after 1 cycle.
6. count 005, blank_lz=1 -> scan shows sel 110/92, 101/FF, 011/FF, each held 2 cycles. blank_lz=0 -> digits 1 and 2 show C0.
